// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at issue time
// and held in a pending register until a fixed-latency countdown commits them.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [63:0]     r_pend;
  logic            r_pend_ok;

  logic        w_is_md;
  logic [63:0] w_v1_sx;
  logic [63:0] w_v2_sx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [31:0] w_qm;
  logic [31:0] w_rm;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic        w_div_zero;

  assign w_is_md   = (op == OpMult) | (op == OpMultu) | (op == OpDiv) | (op == OpDivu);
  assign stall_req = r_busy | (start & w_is_md);

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_v1_sx  = {{32{v1[31]}}, v1};
  assign w_v2_sx  = {{32{v2[31]}}, v2};
  assign w_prod_s = w_v1_sx * w_v2_sx;
  assign w_prod_u = {32'd0, v1} * {32'd0, v2};

  // Signed divide via magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign w_div_zero = (v2 == 32'd0);
  assign w_abs1     = v1[31] ? (32'd0 - v1) : v1;
  assign w_abs2     = v2[31] ? (32'd0 - v2) : v2;
  assign w_qm       = w_div_zero ? 32'd0 : (w_abs1 / w_abs2);
  assign w_rm       = w_div_zero ? 32'd0 : (w_abs1 % w_abs2);
  assign w_q_s      = (v1[31] ^ v2[31]) ? (32'd0 - w_qm) : w_qm;
  assign w_r_s      = v1[31] ? (32'd0 - w_rm) : w_rm;
  assign w_q_u      = w_div_zero ? 32'd0 : (v1 / v2);
  assign w_r_u      = w_div_zero ? 32'd0 : (v1 % v2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend    <= 64'd0;
      r_pend_ok <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            case (op)
              OpMult, OpMultu: begin
                r_pend    <= (op == OpMult) ? w_prod_s : w_prod_u;
                r_pend_ok <= 1'b1;
                r_cnt     <= CntW'(MULT_CYCLES);
                r_busy    <= 1'b1;
                r_state   <= StBusy;
              end
              OpDiv, OpDivu: begin
                r_pend    <= (op == OpDiv) ? {w_r_s, w_q_s} : {w_r_u, w_q_u};
                r_pend_ok <= ~w_div_zero;
                r_cnt     <= CntW'(DIV_CYCLES);
                r_busy    <= 1'b1;
                r_state   <= StBusy;
              end
              OpMthi:  r_hi <= v1;
              OpMtlo:  r_lo <= v1;
              default: ;
            endcase
          end
        end
        StBusy: begin
          // Requests arriving here are dropped; the pipeline is held by stall_req.
          if (r_cnt == CntW'(1)) begin
            if (r_pend_ok) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO results are queued at issue and
// checked by a monitor whenever done pulses.
module tb_md_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] v1;
  logic [31:0] v2;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .v1       (v1),
    .v2       (v2),
    .busy     (busy),
    .stall_req(stall_req),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          dones = 0;
  int          issued = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic; divide by zero leaves HI/LO as they were.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint      sa, sb, q, r;
    logic [63:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'd1: return 64'(sa * sb);
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) return {ch, cl};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {ch, cl};
        uq = {32'd0, a} / {32'd0, b};
        ur = {32'd0, a} % {32'd0, b};
        return {ur[31:0], uq[31:0]};
      end
      default: return {ch, cl};
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      dones++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        chk("commit_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Called and returns at a negedge; md ops return in the cycle done is expected.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int inj_at, input logic [3:0] inj_op, input logic [31:0] inj_v);
    logic [63:0] e;
    logic [31:0] old_hi, old_lo;
    int          n, want;
    bit          md, fin;
    md   = (o >= 4'd1) && (o <= 4'd4);
    want = (o <= 4'd2) ? MultN : DivN;
    start = 1'b1; op = o; v1 = a; v2 = b;
    #1;
    chk("stall_req_issue", {63'd0, stall_req}, {63'd0, md});
    old_hi = m_hi;
    old_lo = m_lo;
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'd0;
    if (md) begin
      e = model(o, a, b, m_hi, m_lo);
      exp_q.push_back(e);
      issued++;
      n = 0;
      fin = 1'b0;
      while (!fin) begin
        @(negedge clk);
        if (!busy) begin
          fin = 1'b1;
        end else begin
          n++;
          chk("hilo_hold", {hi, lo}, {old_hi, old_lo});
          chk("stall_while_busy", {63'd0, stall_req}, 64'd1);
          if (n > 100) begin
            chk("busy_timeout", 64'(n), 64'(want));
            fin = 1'b1;
          end else if (n == inj_at) begin
            start = 1'b1; op = inj_op; v1 = inj_v; v2 = $urandom;
          end else begin
            start = 1'b0; op = 4'd0; v1 = $urandom; v2 = $urandom;
          end
        end
      end
      start = 1'b0; op = 4'd0;
      chk("busy_cycles", 64'(n), 64'(want));
      {m_hi, m_lo} = e;
    end else begin
      if (o == 4'd5) m_hi = a;
      else if (o == 4'd6) m_lo = a;
      chk("direct_hilo", {hi, lo}, {m_hi, m_lo});
      chk("busy_idle", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int          ia;
    reset = 1'b1; start = 1'b0; op = 4'd0; v1 = 32'd0; v2 = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_stall", {63'd0, stall_req}, 64'd0);

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 4'd0, 32'd0);
    chk("mult_m2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, 0, 4'd0, 32'd0);
    chk("multu_m2x3", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 4'd0, 32'd0);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd4, 32'd7, 32'd0, 0, 4'd0, 32'd0);
    chk("divu_by_zero", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'd0, 32'd0);
    chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(4'd5, 32'h1234_5678, 32'd0, 0, 4'd0, 32'd0);
    chk("mthi", {32'd0, hi}, 64'h1234_5678);
    issue(4'd1, 32'h0000_1234, 32'h0000_5678, 2, 4'd6, 32'h0000_DEAD);
    chk("mtlo_ignored_busy", {32'd0, lo}, 64'h0626_0060);
    issue(4'd6, 32'hCAFE_F00D, 32'd0, 0, 4'd0, 32'd0);
    issue(4'd9, 32'h5555_5555, 32'd1, 0, 4'd0, 32'd0);

    // Reset in the fourth busy cycle of a DIV aborts it without a done pulse.
    start = 1'b1; op = 4'd3; v1 = 32'd100; v2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    repeat (DivN + 4) @(negedge clk);
    chk("abort_still_idle", {63'd0, busy}, 64'd0);

    for (int k = 0; k < 60; k++) begin
      ro = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      ia = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      issue(ro, ra, rb, ia, 4'($urandom_range(1, 6)), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("done_count", 64'(dones), 64'(issued));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
